// File: rtl/alu_pkg.sv
// Shared RV32IM ALU operation codes, used by both the decode stage and the EX-stage ALU.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] FWD    = 5'd0;
  localparam logic [4:0] ADD    = 5'd1;
  localparam logic [4:0] SUB    = 5'd2;
  localparam logic [4:0] SLL    = 5'd3;
  localparam logic [4:0] SLT    = 5'd4;
  localparam logic [4:0] SLTU   = 5'd5;
  localparam logic [4:0] XOR    = 5'd6;
  localparam logic [4:0] SRL    = 5'd7;
  localparam logic [4:0] SRA    = 5'd8;
  localparam logic [4:0] OR     = 5'd9;
  localparam logic [4:0] AND    = 5'd10;
  localparam logic [4:0] MUL    = 5'd11;
  localparam logic [4:0] MULH   = 5'd12;
  localparam logic [4:0] MULHSU = 5'd13;
  localparam logic [4:0] MULHU  = 5'd14;
  localparam logic [4:0] DIV    = 5'd15;
  localparam logic [4:0] DIVU   = 5'd16;
  localparam logic [4:0] REM    = 5'd17;
  localparam logic [4:0] REMU   = 5'd18;

endpackage

// File: rtl/alu_rv32im_if.sv
// Operand/opcode/result bundle between the EX-stage issue logic (master) and the ALU (slave).
interface alu_rv32im_if #(parameter int WIDTH = 32);

  logic [WIDTH-1:0] DATA1;
  logic [WIDTH-1:0] DATA2;
  logic [4:0]       SELECT;
  logic [WIDTH-1:0] RESULT;

  modport master (output DATA1, output DATA2, output SELECT, input RESULT);
  modport slave  (input DATA1, input DATA2, input SELECT, output RESULT);

endinterface

// File: rtl/alu_muldiv.sv
// Combinational RV32M unit: single-cycle multiplier and divider with RISC-V corner-case results.
module alu_muldiv
  import alu_pkg::*;
(
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  logic            a_mul_signed;
  logic            b_mul_signed;
  logic [63:0]     a_ext;
  logic [63:0]     b_ext;
  logic [63:0]     prod;

  logic            div_signed;
  logic            a_neg;
  logic            b_neg;
  logic            div_by_zero;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] q_mag;
  logic [XLEN-1:0] r_mag;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  // One 64-bit multiplier serves all four ops: operands are sign- or zero-extended per op,
  // and the low 64 bits of the product are correct for every signedness combination.
  assign a_mul_signed = (op_i == MULH) || (op_i == MULHSU);
  assign b_mul_signed = (op_i == MULH);
  assign a_ext        = {{32{a_mul_signed & a_i[31]}}, a_i};
  assign b_ext        = {{32{b_mul_signed & b_i[31]}}, b_i};
  assign prod         = a_ext * b_ext;

  // Signed division runs on magnitudes; INT_MIN / -1 then wraps to INT_MIN with remainder 0.
  assign div_signed  = (op_i == DIV) || (op_i == REM);
  assign a_neg       = div_signed & a_i[31];
  assign b_neg       = div_signed & b_i[31];
  assign div_by_zero = (b_i == '0);
  assign a_mag       = a_neg ? -a_i : a_i;
  assign b_mag       = b_neg ? -b_i : b_i;
  assign q_mag       = div_by_zero ? '0 : a_mag / b_mag;
  assign r_mag       = div_by_zero ? '0 : a_mag % b_mag;
  assign quotient    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign remainder   = a_neg ? -r_mag : r_mag;

  always_comb begin
    // NOTE: result_o gets a default before the case so no path leaves it unassigned (no latch).
    result_o = '0;
    case (op_i)
      MUL:         result_o = prod[31:0];
      MULH,
      MULHSU,
      MULHU:       result_o = prod[63:32];
      DIV,  DIVU:  result_o = div_by_zero ? '1  : quotient;
      REM,  REMU:  result_o = div_by_zero ? a_i : remainder;
      default:     result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_rv32im.sv
// Registered RV32IM EX-stage ALU: base-ISA ops and result mux here, M-extension in alu_muldiv.
module alu_rv32im
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic         CLK,
  input  logic         RESET,
  alu_rv32im_if.slave  bus
);

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] muldiv_res;
  logic [4:0]       shamt;
  logic             lt_signed;
  logic             lt_unsigned;

  alu_muldiv u_muldiv (
    .op_i     (bus.SELECT),
    .a_i      (bus.DATA1),
    .b_i      (bus.DATA2),
    .result_o (muldiv_res)
  );

  // Only the low five bits of operand B form the shift amount.
  assign shamt       = bus.DATA2[4:0];
  assign lt_signed   = $signed(bus.DATA1) < $signed(bus.DATA2);
  assign lt_unsigned = bus.DATA1 < bus.DATA2;

  always_comb begin
    result_d = '0;
    case (bus.SELECT)
      FWD:    result_d = bus.DATA2;
      ADD:    result_d = bus.DATA1 + bus.DATA2;
      SUB:    result_d = bus.DATA1 - bus.DATA2;
      SLL:    result_d = bus.DATA1 << shamt;
      SLT:    result_d = {{(WIDTH-1){1'b0}}, lt_signed};
      SLTU:   result_d = {{(WIDTH-1){1'b0}}, lt_unsigned};
      XOR:    result_d = bus.DATA1 ^ bus.DATA2;
      SRL:    result_d = bus.DATA1 >> shamt;
      SRA:    result_d = WIDTH'($signed(bus.DATA1) >>> shamt);
      OR:     result_d = bus.DATA1 | bus.DATA2;
      AND:    result_d = bus.DATA1 & bus.DATA2;
      MUL, MULH, MULHSU, MULHU,
      DIV, DIVU, REM, REMU:
              result_d = muldiv_res;
      default: result_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) result_q <= '0;
    else       result_q <= result_d;
  end

  assign bus.RESULT = result_q;

endmodule

// File: tb/tb_alu_rv32im.sv
// Self-checking bench for alu_rv32im: directed corner cases plus random ops against a reference model.
module tb_alu_rv32im;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_rv32im_if #(.WIDTH(32)) bus ();

  alu_rv32im #(.WIDTH(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on 64-bit signed/unsigned values.
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint     sa = longint'($signed(a));
    longint     sb = longint'($signed(b));
    longint     ua = longint'({32'd0, a});
    longint     ub = longint'({32'd0, b});
    int         sh = int'(b[4:0]);
    logic [63:0] p;
    case (op)
      FWD:    return b;
      ADD:    return 32'(ua + ub);
      SUB:    return 32'(ua - ub);
      SLL:    return 32'(ua * (64'd1 << sh));
      SRL:    return 32'(ua / (64'd1 << sh));
      SRA:    return 32'(sa >>> sh);
      SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
      XOR:    return a ^ b;
      OR:     return a | b;
      AND:    return a & b;
      MUL:    begin p = 64'(ua * ub); return p[31:0];  end
      MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      DIV:    return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      DIVU:   return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      REM:    return (b == 0) ? a : 32'(sa % sb);
      REMU:   return (b == 0) ? a : 32'(ua % ub);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.SELECT = op;
    bus.DATA1  = a;
    bus.DATA2  = b;
  endtask

  // One op per cycle: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input string tag, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    drive(op, a, b);
    @(posedge clk);
    #1;
    check(tag, bus.RESULT, exp);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(ADD, 32'h1111_1111, 32'h2222_2222);
    #1;
    check("reset_state", bus.RESULT, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", bus.RESULT, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First edge after reset loads a valid result; then exact one-edge latency.
    step("first_after_reset", SUB, 32'd50, 32'd8, 32'd42);
    @(negedge clk);
    drive(ADD, 32'h10, 32'h20);
    #1;
    check("latency_hold", bus.RESULT, 32'd42);
    @(posedge clk);
    #1;
    check("latency_add", bus.RESULT, 32'h30);

    step("fwd",    FWD,  32'h1234_5678, 32'hABCD_EF00, 32'hABCD_EF00);
    step("add_wrap", ADD, 32'hFFFF_FFFF, 32'd1,        32'd0);
    step("sub_neg", SUB,  32'h10,        32'h20,       32'hFFFF_FFF0);
    step("sll",    SLL,  32'hF0F0_F0F0, 32'd2,        32'hC3C3_C3C0);
    step("srl",    SRL,  32'h8000_0000, 32'd4,        32'h0800_0000);
    step("sra",    SRA,  32'h8000_0000, 32'd4,        32'hF800_0000);
    step("sra_shamt_mask", SRA, 32'h8000_0000, 32'h24, 32'hF800_0000);
    step("sll_shamt_mask", SLL, 32'h0000_0001, 32'h24, 32'h0000_0010);
    step("slt",    SLT,  32'hFFFF_FFF0, 32'h10,       32'd1);
    step("sltu",   SLTU, 32'hFFFF_FFF0, 32'h10,       32'd0);
    step("xor",    XOR,  32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'd0);
    step("or",     OR,   32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF);
    step("and",    AND,  32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'hAAAA_AAAA);

    step("mul",    MUL,    32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFE);
    step("mulh",   MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    step("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF);
    step("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    step("div",      DIV,  32'hFFFF_FFF0, 32'd2, 32'hFFFF_FFF8);
    step("divu",     DIVU, 32'hFFFF_FFF0, 32'd2, 32'h7FFF_FFF8);
    step("rem",      REM,  32'hFFFF_FFF9, 32'd5, 32'hFFFF_FFFE);
    step("remu",     REMU, 32'h17,        32'd5, 32'd3);
    step("div_by0",  DIV,  32'h1234,      32'd0, 32'hFFFF_FFFF);
    step("divu_by0", DIVU, 32'h1234,      32'd0, 32'hFFFF_FFFF);
    step("rem_by0",  REM,  32'h1234,      32'd0, 32'h1234);
    step("remu_by0", REMU, 32'h8000_1234, 32'd0, 32'h8000_1234);
    step("div_ovf",  DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    step("rem_ovf",  REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    step("default_31", 5'd31, 32'h1234_5678, 32'hABCD_EF00, 32'd0);
    step("default_19", 5'd19, 32'h1234_5678, 32'hABCD_EF00, 32'd0);

    // Asynchronous reset mid-cycle with a nonzero result registered.
    step("pre_reset", AND, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", bus.RESULT, 32'd0);
    @(posedge clk);
    #1;
    check("reset_held_edge", bus.RESULT, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step("post_reset", ADD, 32'd5, 32'd6, 32'd11);

    // Random back-to-back ops against the reference model.
    for (int i = 0; i < 400; i++) begin
      op = 5'($urandom_range(0, 31));
      a  = pick_operand();
      b  = pick_operand();
      step($sformatf("rand%0d_op%0d_a%h_b%h", i, op, a, b), op, a, b, ref_alu(op, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
